// File: rtl/lsu_bus_pkg.sv
// Shared types and constants for the load/store unit: FSM states, Funct3 codes,
// and the default bus timeout.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;

  // Stores only have signed-size encodings; loads add the two unsigned ones.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// Word-aligned data bus between the load/store unit (master) and memory (slave).
// Handshake: the master holds BusReq and all request fields stable until the
// slave answers with a one-cycle BusAck; BusRData is only meaningful with BusAck.
interface lsu_bus_if;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [3:0]  BusBe;
  logic [31:0] BusWData;
  logic        BusAck;
  logic [31:0] BusRData;

  modport master (
    output BusReq, BusWe, BusAddr, BusBe, BusWData,
    input  BusAck, BusRData
  );

  modport slave (
    input  BusReq, BusWe, BusAddr, BusBe, BusWData,
    output BusAck, BusRData
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Picks the addressed byte/halfword out of a bus read word and sign- or
// zero-extends it according to the load's Funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_word[{i_off, 3'b000} +: 8];
    w_half   = i_off[1] ? i_word[31:16] : i_word[15:0];
    o_result = i_word;
    case (i_funct3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_BU:   o_result = {24'd0, w_byte};
      F3_HU:   o_result = {16'd0, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit: turns one datapath memory instruction into a single
// request/ack bus transaction, stalling the core until it completes.
module lsu_bus
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  lsu_bus_if.master   bus,
  output lsu_state_e  o_dbg_state
);

  localparam logic        TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  lsu_state_e  r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;

  logic        w_access, w_store, w_bad;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;
  logic        w_start, w_capture;
  logic        w_req, w_we, w_stall, w_fault;
  logic [31:0] w_addr, w_bus_wdata;
  logic [3:0]  w_bus_be;

  assign w_access = MemRead | MemWrite;
  assign w_store  = MemWrite;
  assign w_off    = ALUResult[1:0];

  // Lane placement: Funct3[1:0] encodes size (b/h/w) for both signed and unsigned loads.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'd0;
    case (Funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{WriteData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteData;
      end
    endcase
    if (!w_store) w_wdata = 32'd0;
  end

  always_comb begin
    w_bad = !f3_legal(Funct3, w_store);
    if (Funct3[1:0] == 2'b01 && w_off[0])     w_bad = 1'b1;
    if (Funct3[1:0] == 2'b10 && w_off != 2'd0) w_bad = 1'b1;
  end

  lsu_load_extend u_ext (
    .i_word   (bus.BusRData),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_result (w_ext)
  );

  // Next state and outputs; everything is forced low while reset is asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_stall     = 1'b0;
    w_fault     = 1'b0;
    w_addr      = 32'd0;
    w_bus_be    = 4'd0;
    w_bus_wdata = 32'd0;
    if (reset) begin
      case (r_state)
        IDLE: begin
          if (w_access && w_bad) begin
            w_fault = 1'b1;
          end else if (w_access) begin
            w_start     = 1'b1;
            w_req       = 1'b1;
            w_stall     = 1'b1;
            w_we        = w_store;
            w_addr      = {ALUResult[31:2], 2'b00};
            w_bus_be    = w_be;
            w_bus_wdata = w_wdata;
            w_cnt_nxt   = 32'd0;
            w_state_nxt = WAIT;
          end
        end
        WAIT: begin
          w_req       = 1'b1;
          w_stall     = 1'b1;
          w_we        = r_we;
          w_addr      = r_addr;
          w_bus_be    = r_be;
          w_bus_wdata = r_wdata;
          w_cnt_nxt   = r_cnt + 32'd1;
          if (bus.BusAck) begin
            w_capture   = !r_we;
            w_state_nxt = DONE;
          end else if (TO_EN && r_cnt == TO_LAST) begin
            w_req       = 1'b0;
            w_stall     = 1'b0;
            w_fault     = 1'b1;
            w_cnt_nxt   = 32'd0;
            w_state_nxt = IDLE;
          end
        end
        DONE: begin
          w_cnt_nxt   = 32'd0;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 32'd0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_off   <= 2'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_start) begin
        r_addr  <= {ALUResult[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_we    <= w_store;
        r_f3    <= Funct3;
        r_off   <= w_off;
      end
      if (w_capture) r_rdata <= w_ext;
    end
  end

  assign bus.BusReq   = w_req;
  assign bus.BusWe    = w_we;
  assign bus.BusAddr  = w_addr;
  assign bus.BusBe    = w_bus_be;
  assign bus.BusWData = w_bus_wdata;
  assign ReadData     = r_rdata;
  assign Stall        = w_stall;
  assign Fault        = w_fault;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_lsu_bus.sv
// Bench for lsu_bus: directed vector table, randomized accesses against a
// behavioural model, and hand-written timeout / reset-during-wait sequences.
module tb_lsu_bus;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, Fault;
  lsu_state_e  dbg_state;

  lsu_bus_if bus ();

  lsu_bus #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .ALUResult   (ALUResult),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .Stall       (Stall),
    .Fault       (Fault),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rd;

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ack_dly;
    logic        bad;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Funct3    = 3'd0;
    ALUResult = 32'd0;
    WriteData = 32'd0;
    bus.BusAck = 1'b0;
  endtask

  // Expected behaviour derived from the access rules, not from the FSM.
  function automatic void ref_model(input logic ld, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    input logic [31:0] rd, output logic bad,
                                    output logic [3:0] be, output logic [31:0] ewd,
                                    output logic [31:0] erd);
    int bytes, off;
    bit sgn;
    logic [31:0] mask, v;
    off = int'(addr % 4);
    bytes = 0;
    sgn = 1'b0;
    case (f3)
      3'd0: begin bytes = 1; sgn = 1'b1; end
      3'd1: begin bytes = 2; sgn = 1'b1; end
      3'd2: bytes = 4;
      3'd4: if (ld) bytes = 1;
      3'd5: if (ld) bytes = 2;
      default: bytes = 0;
    endcase
    if (bytes == 0) bad = 1'b1;
    else bad = (off % bytes) != 0;
    be = 4'(((1 << bytes) - 1) << off);
    if (bytes == 1) ewd = {24'd0, wd[7:0]} * 32'h01010101;
    else if (bytes == 2) ewd = {16'd0, wd[15:0]} * 32'h00010001;
    else ewd = wd;
    mask = (bytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 32'd1);
    v = (rd >> (8 * off)) & mask;
    if (sgn && bytes > 0 && bytes < 4 && v[8 * bytes - 1]) v = v | ~mask;
    erd = v;
  endfunction

  // One instruction from request to return-to-idle. ack_dly is the WAIT-cycle
  // index on which the slave acks; values >= TO mean the slave never answers.
  task automatic run_access(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int ack_dly,
                            input logic e_bad, input logic [3:0] e_be,
                            input logic [31:0] e_wd, input logic [31:0] e_rd);
    logic [31:0] e_addr;
    e_addr = {addr[31:2], 2'b00};
    @(negedge clk);
    MemRead   = ld;
    MemWrite  = !ld;
    Funct3    = f3;
    ALUResult = addr;
    WriteData = wd;
    bus.BusAck = 1'b0;
    #1;
    if (e_bad) begin
      check("bad_fault", 32'(Fault), 32'd1);
      check("bad_req", 32'(bus.BusReq), 32'd0);
      check("bad_stall", 32'(Stall), 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      check("bad_fault_pulse", 32'(Fault), 32'd0);
      check("bad_state", 32'(dbg_state), 32'(IDLE));
      return;
    end
    check("req_cycle_req", 32'(bus.BusReq), 32'd1);
    check("req_cycle_stall", 32'(Stall), 32'd1);
    check("req_cycle_fault", 32'(Fault), 32'd0);
    check("req_addr", bus.BusAddr, e_addr);
    check("req_be", 32'(bus.BusBe), 32'(e_be));
    check("req_we", 32'(bus.BusWe), 32'(!ld));
    if (!ld) check("req_wdata", bus.BusWData, e_wd);
    for (int j = 0; j < TO; j++) begin
      @(negedge clk);
      bus.BusAck   = (j == ack_dly);
      bus.BusRData = bus.BusAck ? rd : $urandom;
      #1;
      if (j == ack_dly || j != TO - 1) begin
        check("wait_stall", 32'(Stall), 32'd1);
        check("wait_req", 32'(bus.BusReq), 32'd1);
        check("wait_fault", 32'(Fault), 32'd0);
        check("wait_addr", bus.BusAddr, e_addr);
        check("wait_be", 32'(bus.BusBe), 32'(e_be));
        if (!ld) check("wait_wdata", bus.BusWData, e_wd);
      end else begin
        check("timeout_fault", 32'(Fault), 32'd1);
        check("timeout_stall", 32'(Stall), 32'd0);
      end
      if (j == ack_dly) begin
        if (ld) model_rd = e_rd;
        exp_q.push_back(model_rd);
        @(negedge clk);
        bus.BusAck = 1'b0;
        #1;
        check("done_state", 32'(dbg_state), 32'(DONE));
        check("done_stall", 32'(Stall), 32'd0);
        check("done_req", 32'(bus.BusReq), 32'd0);
        check("done_fault", 32'(Fault), 32'd0);
        check("done_rdata", ReadData, exp_q.pop_front());
        @(negedge clk);
        idle_inputs();
        #1;
        check("after_done_state", 32'(dbg_state), 32'(IDLE));
        check("after_done_req", 32'(bus.BusReq), 32'd0);
        return;
      end
      if (j == TO - 1) begin
        @(negedge clk);
        idle_inputs();
        #1;
        check("after_to_state", 32'(dbg_state), 32'(IDLE));
        check("after_to_fault", 32'(Fault), 32'd0);
        check("after_to_rdata", ReadData, model_rd);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic        r_bad;
    logic [3:0]  r_be;
    logic [31:0] r_wd, r_rd, a;

    tbl[0] = '{1'b1, F3_W,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1,  1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    tbl[1] = '{1'b1, F3_B,  32'h0000_0203, 32'h0,         32'h8011_2233, 0,  1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
    tbl[2] = '{1'b1, F3_BU, 32'h0000_0203, 32'h0,         32'h8011_2233, 2,  1'b0, 4'b1000, 32'h0,         32'h0000_0080};
    tbl[3] = '{1'b0, F3_H,  32'h0000_0102, 32'h0000_ABCD, 32'h0,         0,  1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    tbl[4] = '{1'b1, F3_W,  32'h0000_1001, 32'h0,         32'h0,         0,  1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[5] = '{1'b1, 3'b011, 32'h0000_1000, 32'h0,        32'h0,         0,  1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[6] = '{1'b0, F3_B,  32'h0000_0101, 32'h1234_5678, 32'h0,         3,  1'b0, 4'b0010, 32'h7878_7878, 32'h0};
    tbl[7] = '{1'b1, F3_H,  32'h0000_0102, 32'h0,         32'h8011_2233, 1,  1'b0, 4'b1100, 32'h0,         32'hFFFF_8011};
    tbl[8] = '{1'b1, F3_HU, 32'h0000_0102, 32'h0,         32'h8011_2233, 0,  1'b0, 4'b1100, 32'h0,         32'h0000_8011};
    tbl[9] = '{1'b0, F3_BU, 32'h0000_0100, 32'h0000_0055, 32'h0,         0,  1'b1, 4'b0000, 32'h0,         32'h0};

    reset = 1'b0;
    idle_inputs();
    bus.BusRData = 32'd0;
    model_rd = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_rdata", ReadData, 32'd0);
    check("rst_req", 32'(bus.BusReq), 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);
    check("rst_be", 32'(bus.BusBe), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      v = tbl[i];
      run_access(v.ld, v.f3, v.addr, v.wd, v.rd, v.ack_dly, v.bad, v.be, v.ewd, v.erd);
    end

    // Store with no ack: timeout, then a stray ack must not disturb anything.
    run_access(1'b0, F3_W, 32'h0000_0200, 32'h1111_2222, 32'h0, 99, 1'b0, 4'b1111,
               32'h1111_2222, 32'h0);
    @(negedge clk);
    bus.BusAck   = 1'b1;
    bus.BusRData = 32'h5555_AAAA;
    #1;
    check("late_ack_req", 32'(bus.BusReq), 32'd0);
    check("late_ack_stall", 32'(Stall), 32'd0);
    @(negedge clk);
    bus.BusAck = 1'b0;
    #1;
    check("late_ack_state", 32'(dbg_state), 32'(IDLE));
    check("late_ack_rdata", ReadData, model_rd);

    // Reset pulled in the middle of a WAIT.
    @(negedge clk);
    MemRead   = 1'b1;
    Funct3    = F3_W;
    ALUResult = 32'h0000_0300;
    #1;
    check("rw_req", 32'(bus.BusReq), 32'd1);
    @(negedge clk);
    #1;
    check("rw_wait", 32'(dbg_state), 32'(WAIT));
    #2;
    reset = 1'b0;
    #1;
    model_rd = 32'd0;
    check("rw_req_drop", 32'(bus.BusReq), 32'd0);
    check("rw_stall_drop", 32'(Stall), 32'd0);
    check("rw_rdata", ReadData, 32'd0);
    check("rw_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    idle_inputs();
    bus.BusAck   = 1'b1;
    bus.BusRData = 32'h1234_5678;
    #1;
    check("rw_late_ack_req", 32'(bus.BusReq), 32'd0);
    @(negedge clk);
    bus.BusAck = 1'b0;
    reset = 1'b1;
    #1;
    check("rw_after_rdata", ReadData, 32'd0);
    run_access(1'b1, F3_W, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 4'b1111,
               32'h0, 32'hCAFE_F00D);

    // Randomized accesses; ack index TO means no ack (timeout).
    for (int i = 0; i < 60; i++) begin
      logic        ld;
      logic [2:0]  f3;
      logic [31:0] wd, rd;
      int          dly;
      ld  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'b01) ? 2'($urandom_range(0, 1) * 2)
                                              : (f3[1:0] == 2'b10) ? 2'd0 : a[1:0];
      wd  = $urandom;
      rd  = $urandom;
      dly = $urandom_range(0, TO);
      ref_model(ld, f3, a, wd, rd, r_bad, r_be, r_wd, r_rd);
      run_access(ld, f3, a, wd, rd, dly, r_bad, r_be, r_wd, r_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus.md
Name: lsu_bus

Overview:
- Load/store unit directly downstream of the single-cycle datapath.
- Consumes the datapath's effective address (ALUResult), store data (WriteData) and memory-control bits; returns ReadData to the datapath's result mux.
- Converts each lb/lh/lw/lbu/lhu/sb/sh/sw into one word-aligned request/acknowledge transaction on the data bus.
- Holds the core via Stall until the bus acknowledges.

Parameters:
TIMEOUT, 255, cycles to wait for BusAck before aborting with Fault; 0 disables the timeout.

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately)
MemRead  in  1  current instruction is a load
MemWrite  in  1  current instruction is a store (wins if both asserted)
Funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
ALUResult  in  32  byte address
WriteData  in  32  store data (rs2)
ReadData  out  32  extended load result
Stall  out  1  freeze PC/regfile write this cycle
Fault  out  1  misaligned, illegal Funct3, or timeout; one-cycle pulse
BusReq  out  1  request valid
BusWe  out  1  1=write
BusAddr  out  32  {ALUResult[31:2],2'b00}
BusBe  out  4  byte-lane enables
BusWData  out  32  lane-positioned store data
BusAck  in  1  slave completion, single-cycle pulse
BusRData  in  32  read word, valid with BusAck

Behaviour:
- FSM states: IDLE, WAIT, DONE.
- Reset values: state=IDLE, ReadData=0, timeout counter=0. All bus outputs and Stall/Fault are 0 at reset.
- Access = MemRead|MemWrite.
- Bad condition (bad=1) when any of these holds:
  - Funct3 is 011, 110 or 111 (loads); for stores, any Funct3 other than 000/001/010.
  - A halfword access has addr[0]=1.
  - A word access has addr[1:0]!=0.
- IDLE:
  - Access & bad: Fault=1, Stall=0, no BusReq, stay IDLE.
  - Access & !bad: BusReq=1 and Stall=1 combinationally; go to WAIT.
  - Registers address, Be, WData, We and Funct3/addr[1:0] at that edge.
- WAIT:
  - BusReq=1 with registered bus fields held stable; Stall=1.
  - On BusAck: for loads, ReadData <= extend(BusRData); go to DONE.
  - Counter increments each WAIT cycle. When TIMEOUT!=0 and counter==TIMEOUT-1 without ack: Fault=1, Stall=0, go to IDLE, ReadData unchanged.
  - An ack arriving on the same cycle as the timeout takes priority over the timeout.
- DONE:
  - Stall=0, BusReq=0; ReadData valid. The datapath commits the instruction at this edge.
  - Always go to IDLE; the access inputs are ignored in DONE, so the same instruction is never retriggered.
- Latency: minimum 2 cycles per access (request cycle, ack cycle) plus the DONE cycle.
- Byte lanes, with o=addr[1:0]:
  - b: Be=4'b0001<<o, WData=byte replicated ×4.
  - h: Be=4'b0011<<o, WData=half replicated ×2.
  - w: Be=4'b1111, WData=WriteData.
  - Loads drive Be the same way and BusWe=0.
- Load extend: select lane by o; b/h sign-extend, bu/hu zero-extend, w passes through.
- BusRData is ignored when BusAck=0. An ack seen in IDLE or DONE is ignored.
- Reset asserted mid-WAIT: BusReq drops asynchronously, state returns to IDLE, the transaction is abandoned, and a late ack is ignored.

Decomposition:
- Package lsu_pkg holds:
  - the state enum (IDLE/WAIT/DONE);
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the default TIMEOUT.
- One combinational sub-module, lsu_load_extend (32-bit word, offset, Funct3 → 32-bit result), instantiated once.
- Lane placement stays inline.

Test Plan:
1. lw addr 0x100, ack 2 cycles after request with BusRData=0xDEADBEEF → BusAddr=0x100, Be=1111; Stall high 3 cycles; ReadData=0xDEADBEEF in DONE.
2. lb addr 0x203, BusRData=0x80112233 → Be=1000, ReadData=0xFFFFFF80. Repeat as lbu → 0x00000080.
3. sh addr 0x102, WriteData=0x0000ABCD → BusWe=1, Be=1100, BusWData=0xABCDABCD, Stall drops in DONE.
4. lw addr 0x1001 and Funct3=011 load → Fault pulse, BusReq never asserted, Stall=0.
5. sw with TIMEOUT=4 and no ack → Fault after 4 WAIT cycles, state IDLE; an ack arriving later is ignored.
6. reset=0 during WAIT → BusReq=0 immediately, ReadData=0. After release, a new lw completes normally.
